seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK_CYCLES, default 500: anti-ghost blank cycles at the start of each slot; SHALL be less than REFRESH_DIV.
REQ-003 Parameter BLANK_LEADING, default 1: 1 suppresses leading zeros, 0 shows all digits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 load  input  1  one-cycle strobe; samples value.
REQ-007 value  input  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-008 seg  output  7  registered, active-low segments, order a..g MSB..LSB; codes 0..9 = 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100; nibble >9 = 1111111.
REQ-009 an  output  4  registered, active-low digit enables; an[k] drives digit k.
REQ-010 pending  output  1  high while a loaded value waits for the frame boundary.
REQ-011 frame_start  output  1  one-cycle pulse, registered, in the cycle the digit 0 slot begins.

Function
REQ-012 div_cnt counts 0..REFRESH_DIV-1 and wraps; digit_idx advances 0->1->2->3->0 at each div_cnt wrap.
REQ-013 Frame boundary = cycle in which digit_idx changes from 3 to 0.
REQ-014 load with no boundary: value written to shadow register; pending set to 1.
REQ-015 load while pending is already 1: shadow overwritten; last load wins; pending stays 1.
REQ-016 Boundary with pending=1 and no load: disp register takes shadow; pending cleared.
REQ-017 load in the boundary cycle: value written directly to disp register; shadow also takes value; pending cleared. Old shadow is discarded.
REQ-018 disp register changes only at frame boundaries, so no tearing within a frame.
REQ-019 Blank window: while div_cnt < BLANK_CYCLES, an = 1111 and seg = 1111111.
REQ-020 Outside the blank window, an has only bit digit_idx low, and seg shows the decode of disp nibble digit_idx.
REQ-021 Leading-zero suppression (BLANK_LEADING=1): digit k (k=1..3) is suppressed when disp nibbles k..3 are all zero. A suppressed digit drives an = 1111 and seg = 1111111. Digit 0 is never suppressed.
REQ-022 Output latency: seg, an and frame_start are registered, one cycle after the counter state that selects them.
REQ-023 an SHALL never have more than one bit low in any cycle.

Reset
REQ-024 rst_n low asynchronously forces: div_cnt=0, digit_idx=0, disp=0, shadow=0, pending=0, seg=1111111, an=1111, frame_start=0.
REQ-025 rst_n low mid-frame or with a pending value discards that value. Scanning restarts at digit 0, with the first frame_start REFRESH_DIV*4 cycles after rst_n deassertion.
REQ-026 Deassertion is synchronous to clk; the first count occurs on the first rising edge after release.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 Reset, then no load -> digit 0 slot shows an=1110, seg=0000001 for 6 cycles per slot; digits 1..3 stay an=1111 with BLANK_LEADING=1.
REQ-028 load value=16'h1234 mid-frame -> pending=1 until the boundary. The next frame shows digit3=1001111, digit2=0010010, digit1=0000110, digit0=1001100; pending=0.
REQ-029 Two loads 16'h0005 then 16'h0987 in the same frame -> the next frame shows 0987 with digit 3 suppressed (an never 0111).
REQ-030 load 16'h4321 exactly in the boundary cycle -> the frame that starts then shows 4321; pending never rises.
REQ-031 value=16'h00A9 with BLANK_LEADING=0 -> digit1=1111111 (invalid nibble), digit0=0000100, digits 3 and 2 show 0000001.
REQ-032 rst_n low during the digit 2 slot with pending=1 -> outputs blank immediately; pending=0; after release, disp=0000 and frame_start pulses 32 cycles later.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous double-buffered value.
// seg/an/frame_start are registered, one cycle behind the scan counters; there is no backpressure and load is always accepted.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_start
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] div_cnt;
  logic [1:0]    digit_idx;
  logic [15:0]   disp;
  logic [15:0]   shadow;
  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic          suppress;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (digit_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= 2'd0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      div_cnt   <= div_cnt + CW'(1);
    end
  end

  // disp only moves at the frame boundary so a frame never mixes two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        disp   <= value;
        shadow <= value;
      end else if (pending) begin
        disp   <= shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value;
      pending <= 1'b1;
    end
  end

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b0000001;
      4'd1:    bcd_to_seg = 7'b1001111;
      4'd2:    bcd_to_seg = 7'b0010010;
      4'd3:    bcd_to_seg = 7'b0000110;
      4'd4:    bcd_to_seg = 7'b1001100;
      4'd5:    bcd_to_seg = 7'b0100100;
      4'd6:    bcd_to_seg = 7'b0100000;
      4'd7:    bcd_to_seg = 7'b0001111;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0000100;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    nib      = disp[{digit_idx, 2'b00} +: 4];
    suppress = 1'b0;
    seg_nxt  = 7'b1111111;
    an_nxt   = 4'b1111;
    if (BLANK_LEADING != 0) begin
      case (digit_idx)
        2'd1:    suppress = (disp[15:4]  == 12'd0);
        2'd2:    suppress = (disp[15:8]  == 8'd0);
        2'd3:    suppress = (disp[15:12] == 4'd0);
        default: suppress = 1'b0;
      endcase
    end
    // Blank window at the top of each slot hides ghosting while anodes switch.
    if ((div_cnt >= BLANK_END) && !suppress) begin
      an_nxt  = ~(4'b0001 << digit_idx);
      seg_nxt = bcd_to_seg(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= 7'b1111111;
      an          <= 4'b1111;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (leading-zero blanking on/off) against a phase-based reference model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [6:0]  seg1, seg0;
  logic [3:0]  an1, an0;
  logic        pend1, pend0, fs1, fs0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .seg(seg1), .an(an1), .pending(pend1), .frame_start(fs1)
  );

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .seg(seg0), .an(an0), .pending(pend0), .frame_start(fs0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Model: scan position within the frame is just the cycle count modulo FRAME.
  int          p;
  int          p_prev;
  logic [15:0] m_disp, m_shadow, d_prev;
  logic        m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p        <= 0;
      p_prev   <= 0;
      m_disp   <= 16'h0000;
      m_shadow <= 16'h0000;
      d_prev   <= 16'h0000;
      m_pend   <= 1'b0;
    end else begin
      p_prev <= p;
      d_prev <= m_disp;
      p      <= (p + 1) % FRAME;
      if (p == FRAME - 1) begin
        if (load) begin
          m_disp   <= value;
          m_shadow <= value;
        end else if (m_pend) begin
          m_disp   <= m_shadow;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_shadow <= value;
        m_pend   <= 1'b1;
      end
    end
  end

  function automatic bit is_dark(input int ph, input logic [15:0] d, input bit bl);
    int k;
    k = ph / DIV;
    if ((ph % DIV) < BLK) return 1'b1;
    if (bl && k > 0 && (d >> (4 * k)) == 16'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] ref_seg(input int ph, input logic [15:0] d, input bit bl);
    logic [3:0] nib;
    nib = d[4 * (ph / DIV) +: 4];
    if (is_dark(ph, d, bl) || nib > 4'd9) return 7'b1111111;
    return seg_tab[nib];
  endfunction

  function automatic logic [3:0] ref_an(input int ph, input logic [15:0] d, input bit bl);
    logic [3:0] one;
    one = 4'b0001;
    if (is_dark(ph, d, bl)) return 4'b1111;
    return ~(one << (ph / DIV));
  endfunction

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("seg_lz",   32'(seg1),  32'(ref_seg(p_prev, d_prev, 1'b1)));
      chk("an_lz",    32'(an1),   32'(ref_an(p_prev, d_prev, 1'b1)));
      chk("seg_all",  32'(seg0),  32'(ref_seg(p_prev, d_prev, 1'b0)));
      chk("an_all",   32'(an0),   32'(ref_an(p_prev, d_prev, 1'b0)));
      chk("pend_lz",  32'(pend1), 32'(m_pend));
      chk("pend_all", 32'(pend0), 32'(m_pend));
      chk("fs_lz",    32'(fs1),   32'(rst_n && p_prev == FRAME - 1 && p == 0));
      chk("fs_all",   32'(fs0),   32'(rst_n && p_prev == FRAME - 1 && p == 0));
      chk("an_onehot", 32'($countones(~an1) <= 1 && $countones(~an0) <= 1), 32'd1);
    end
  end

  logic [6:0] seen1 [4];
  logic [6:0] seen0 [4];
  int         lit1  [4];
  int         lit0  [4];

  task automatic wait_phase(input int ph);
    int w;
    w = 0;
    while (p != ph && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("wait_phase", 32'(p == ph), 32'd1);
  endtask

  task automatic do_load(input int ph, input logic [15:0] v);
    wait_phase(ph);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Waits for frame_start, then records what each digit showed over the next full frame.
  task automatic observe_frame();
    int w;
    logic [3:0] one;
    one = 4'b0001;
    w = 0;
    while (!fs1 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("fs_seen", 32'(fs1), 32'd1);
    for (int k = 0; k < 4; k++) begin
      seen1[k] = 7'b1010101;
      seen0[k] = 7'b1010101;
      lit1[k]  = 0;
      lit0[k]  = 0;
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (an1 == ~(one << k)) begin seen1[k] = seg1; lit1[k]++; end
        if (an0 == ~(one << k)) begin seen0[k] = seg0; lit0[k]++; end
      end
    end
  endtask

  initial begin
    int c0, c_other, dly;
    logic [15:0] mask;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_seg",  32'(seg1),  32'h7F);
    chk("rst_an",   32'(an1),   32'hF);
    chk("rst_pend", 32'(pend1), 32'd0);
    chk("rst_fs",   32'(fs1),   32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle after reset: only digit 0 lights, showing 0, six cycles per slot.
    c0 = 0;
    c_other = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (an1 == 4'b1110 && seg1 == 7'b0000001) c0++;
      if (an1[3:1] != 3'b111) c_other++;
    end
    chk("idle_d0_cycles", 32'(c0), 32'd6);
    chk("idle_d123_dark", 32'(c_other), 32'd0);

    do_load(10, 16'h1234);
    chk("pend_after_load", 32'(pend1), 32'd1);
    observe_frame();
    chk("f1234_d3", 32'(seen1[3]), 32'(7'b1001111));
    chk("f1234_d2", 32'(seen1[2]), 32'(7'b0010010));
    chk("f1234_d1", 32'(seen1[1]), 32'(7'b0000110));
    chk("f1234_d0", 32'(seen1[0]), 32'(7'b1001100));
    chk("f1234_pend", 32'(pend1), 32'd0);

    do_load(5, 16'h0005);
    do_load(20, 16'h0987);
    observe_frame();
    chk("f0987_d3_dark", 32'(lit1[3]), 32'd0);
    chk("f0987_d2", 32'(seen1[2]), 32'(7'b0000100));
    chk("f0987_d1", 32'(seen1[1]), 32'(7'b0000000));
    chk("f0987_d0", 32'(seen1[0]), 32'(7'b0001111));
    chk("f0987_nb_d3", 32'(seen0[3]), 32'(7'b0000001));

    do_load(FRAME - 1, 16'h4321);
    chk("bnd_pend", 32'(pend1), 32'd0);
    observe_frame();
    chk("f4321_d3", 32'(seen1[3]), 32'(7'b1001100));
    chk("f4321_d2", 32'(seen1[2]), 32'(7'b0000110));
    chk("f4321_d1", 32'(seen1[1]), 32'(7'b0010010));
    chk("f4321_d0", 32'(seen1[0]), 32'(7'b1001111));

    do_load(10, 16'h00A9);
    observe_frame();
    chk("f00a9_nb_d3", 32'(seen0[3]), 32'(7'b0000001));
    chk("f00a9_nb_d2", 32'(seen0[2]), 32'(7'b0000001));
    chk("f00a9_nb_d1", 32'(seen0[1]), 32'(7'b1111111));
    chk("f00a9_nb_d1_lit", 32'(lit0[1]), 32'd6);
    chk("f00a9_nb_d0", 32'(seen0[0]), 32'(7'b0000100));
    chk("f00a9_lz_d3_dark", 32'(lit1[3]), 32'd0);

    // Reset in the digit 2 slot with a value still pending.
    do_load(3, 16'h5555);
    wait_phase(2 * DIV + 3);
    chk("pre_rst_pend", 32'(pend1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",  32'(seg1),  32'h7F);
    chk("mid_rst_an",   32'(an1),   32'hF);
    chk("mid_rst_pend", 32'(pend1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dly = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (fs1) begin
        dly = i;
        break;
      end
    end
    chk("rst_fs_delay", 32'(dly), 32'(FRAME));
    observe_frame();
    chk("post_rst_d0", 32'(seen1[0]), 32'(7'b0000001));
    chk("post_rst_d3_dark", 32'(lit1[3]), 32'd0);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      value = 16'($urandom) & mask;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
